// File: rtl/mat_pkg.sv
// Shared types, defaults and element-order mapping for the result drain.
// MAT_DRAIN_TRANSPOSE_EN selects column-major drain order.
package mat_pkg;

  localparam int MAT_N     = 6;
  localparam int MAT_W     = 27;
  localparam int MAT_OUT_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    STREAM,
    DONE
  } drain_state_t;

  // Step number -> element index of an n x n bank.
  function automatic logic [31:0] drain_map(
    input logic [31:0] s,
    input logic [31:0] n
  );
`ifdef MAT_DRAIN_TRANSPOSE_EN
    return (s % n) * n + (s / n);
`else
    return (s / n) * n + (s % n);
`endif
  endfunction

endpackage

// File: rtl/mat_result_drain.sv
// Snapshots an N x N result bank and streams it out over valid/ready.
// Element order follows MAT_DRAIN_TRANSPOSE_EN (see mat_pkg).
module mat_result_drain
  import mat_pkg::*;
#(
  parameter int N     = MAT_N,
  parameter int W     = MAT_W,
  parameter int OUT_W = MAT_OUT_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [N*N*W-1:0]        result_in,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic [OUT_W-1:0]        out_data,
  output logic [$clog2(N*N)-1:0]  out_index,
  output logic                    out_last,
  output logic                    busy,
  output logic                    done,
  output logic                    start_err
);

  localparam int NN = N * N;
  localparam int IW = $clog2(NN);
  localparam logic [IW-1:0] LAST = IW'(NN - 1);

  drain_state_t   state_q, state_d;
  logic [IW-1:0]  cnt_q, cnt_d;
  logic           err_q, err_d;
  logic [NN*W-1:0] snap_q;

  logic [IW-1:0]  idx;
  logic [W-1:0]   elem;
  logic           valid;
  logic           last;
  logic           in_busy;

  assign idx     = IW'(drain_map(32'(cnt_q), 32'(N)));
  assign elem    = snap_q[idx*W +: W];
  assign valid   = (state_q == STREAM);
  assign last    = valid && (cnt_q == LAST);
  assign in_busy = (state_q == CAPTURE) || (state_q == STREAM);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Snapshot is data-only; reset leaves it as is.
  always_ff @(posedge clk) begin
    if (state_q == CAPTURE) begin
      snap_q <= result_in;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    if (start && in_busy) begin
      err_d = 1'b1;
    end
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        cnt_d   = '0;
        state_d = STREAM;
      end
      STREAM: begin
        if (out_ready) begin
          if (last) begin
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign out_valid = valid;
  assign out_data  = valid ? OUT_W'(signed'(elem)) : '0;
  assign out_index = valid ? idx : '0;
  assign out_last  = last;
  assign busy      = in_busy;
  assign done      = (state_q == DONE);
  assign start_err = err_q;

endmodule

// File: tb/tb_mat_result_drain.sv
// Directed bench for mat_result_drain: vector table plus stall,
// restart-while-busy and mid-stream reset sequences.
module tb_mat_result_drain;

  localparam int N  = 6;
  localparam int W  = 27;
  localparam int OW = 32;
  localparam int NN = N * N;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [NN*W-1:0]   result_in = '0;
  logic              out_ready = 1'b0;
  logic              out_valid;
  logic [OW-1:0]     out_data;
  logic [5:0]        out_index;
  logic              out_last;
  logic              busy;
  logic              done;
  logic              start_err;

  int errors = 0;
  int checks = 0;
  logic [W-1:0]  bank [NN];
  logic [OW-1:0] got  [NN];
  logic          exp_err = 1'b0;

  mat_result_drain dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .result_in (result_in),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_index (out_index),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done),
    .start_err (start_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]  e0;
    logic [W-1:0]  e35;
    logic [OW-1:0] x0;
    logic [OW-1:0] x35;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  function automatic int mapi(input int s);
`ifdef MAT_DRAIN_TRANSPOSE_EN
    return (s % N) * N + (s / N);
`else
    return s;
`endif
  endfunction

  function automatic logic [OW-1:0] sx(input logic [W-1:0] e);
    return {{(OW-W){e[W-1]}}, e};
  endfunction

  task automatic chk_idle(input string nm);
    chk({nm, "_valid"}, 64'(out_valid), 64'(0));
    chk({nm, "_busy"},  64'(busy), 64'(0));
    chk({nm, "_done"},  64'(done), 64'(0));
    chk({nm, "_last"},  64'(out_last), 64'(0));
    chk({nm, "_data"},  64'(out_data), 64'(0));
    chk({nm, "_index"}, 64'(out_index), 64'(0));
    chk({nm, "_err"},   64'(start_err), 64'(0));
  endtask

  task automatic drain(input bit tog, input int st_at, input int rst_at);
    int beats = 0;
    int cyc = 0;
    bit stall = 0;
    bit sent = 0;
    logic [OW-1:0] pd = '0;
    logic [5:0] pi = '0;
    logic pl = 1'b0;
    for (int k = 0; k < NN; k++) result_in[k*W +: W] = bank[k];
    @(negedge clk);
    start = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("capture_valid", 64'(out_valid), 64'(0));
    chk("capture_busy", 64'(busy), 64'(1));
    @(negedge clk);
    chk("first_valid", 64'(out_valid), 64'(1));
    // Scramble the live bank: streamed data must come from the snapshot.
    for (int k = 0; k < NN; k++) result_in[k*W +: W] = ~bank[k];
    while (beats < NN && cyc < 1000) begin
      if (beats == rst_at) begin
        rst = 1'b0;
        @(negedge clk);
        chk_idle("midrst");
        rst = 1'b1;
        exp_err = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("midrst_novalid", 64'(out_valid), 64'(0));
        end
        return;
      end
      chk("stream_valid", 64'(out_valid), 64'(1));
      if (stall) begin
        chk("hold_data", 64'(out_data), 64'(pd));
        chk("hold_index", 64'(out_index), 64'(pi));
        chk("hold_last", 64'(out_last), 64'(pl));
      end
      out_ready = tog ? (cyc % 2 == 1) : 1'b1;
      if (beats == st_at && !sent) begin
        start = 1'b1;
        sent = 1;
        exp_err = 1'b1;
      end
      if (out_valid && out_ready) begin
        chk("beat_data", 64'(out_data), 64'(sx(bank[mapi(beats)])));
        chk("beat_index", 64'(out_index), 64'(mapi(beats)));
        chk("beat_last", 64'(out_last), 64'(beats == NN - 1));
        got[beats] = out_data;
        beats++;
        stall = 0;
      end else begin
        stall = 1;
        pd = out_data;
        pi = out_index;
        pl = out_last;
      end
      cyc++;
      @(negedge clk);
      start = 1'b0;
    end
    chk("beat_count", 64'(beats), 64'(NN));
    chk("done_pulse", 64'(done), 64'(1));
    chk("done_valid", 64'(out_valid), 64'(0));
    chk("done_busy", 64'(busy), 64'(0));
    chk("done_err", 64'(start_err), 64'(exp_err));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("done_once", 64'(done), 64'(0));
    chk("post_err", 64'(start_err), 64'(exp_err));
    @(negedge clk);
    chk("post_idle_busy", 64'(busy), 64'(0));
  endtask

  vec_t tv [5];

  initial begin
    tv[0] = '{e0: 27'd0,       e35: 27'd35,      x0: 32'd0,        x35: 32'd35};
    tv[1] = '{e0: 27'h4000000, e35: 27'd35,      x0: 32'hFC000000, x35: 32'd35};
    tv[2] = '{e0: 27'h7FFFFFF, e35: 27'h3FFFFFF, x0: 32'hFFFFFFFF, x35: 32'h03FFFFFF};
    tv[3] = '{e0: 27'd0,       e35: 27'h4000001, x0: 32'd0,        x35: 32'hFC000001};
    tv[4] = '{e0: 27'h0000123, e35: 27'h7FFFFFE, x0: 32'h00000123, x35: 32'hFFFFFFFE};

    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk_idle("reset");
    rst = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      for (int k = 0; k < NN; k++) bank[k] = W'(k);
      bank[0] = tv[v].e0;
      bank[NN-1] = tv[v].e35;
      drain(0, -1, -1);
      chk("vec_first", 64'(got[0]), 64'(tv[v].x0));
      chk("vec_last", 64'(got[NN-1]), 64'(tv[v].x35));
`ifdef MAT_DRAIN_TRANSPOSE_EN
      chk("vec_beat1", 64'(got[1]), 64'(6));
`else
      chk("vec_beat1", 64'(got[1]), 64'(1));
`endif
    end

    for (int k = 0; k < NN; k++) bank[k] = W'(k * 3 + 100);
    drain(1, -1, -1);

    for (int k = 0; k < NN; k++) bank[k] = W'(k);
    drain(0, 10, -1);
    repeat (3) @(negedge clk);
    chk("err_sticky", 64'(start_err), 64'(1));

    drain(0, -1, 20);
    chk("err_cleared", 64'(start_err), 64'(0));
    drain(0, -1, -1);
    chk("after_rst_err", 64'(start_err), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
